// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sequences loads/stores against a stallable multi-cycle
// data memory, registers MEM/WB, and exports forwarding info back to execute.
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [15:0] alu_result,
   input  logic [15:0] write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Rd_in,
   input  logic        Rd_valid_in,
   input  logic        WriteReg_in,
   output logic        stall_out,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_stall,
   input  logic        mem_done,
   output logic [2:0]  Rd_ex_mem,
   output logic        Rd_valid_ex_mem,
   output logic        WriteReg_ex_mem,
   output logic [15:0] fwd_data,
   output logic        fwd_data_ready,
   output logic        wb_valid,
   output logic [15:0] wb_data,
   output logic [2:0]  wb_Rd,
   output logic        wb_WriteReg,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [2:0]  req_rd;
   logic        req_rd_valid;
   logic        req_wreg;
   logic        wb_rd_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         req_wr       <= 1'b0;
         req_addr     <= '0;
         req_wdata    <= '0;
         req_rd       <= '0;
         req_rd_valid <= 1'b0;
         req_wreg     <= 1'b0;
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_Rd        <= '0;
         wb_WriteReg  <= 1'b0;
         wb_rd_valid  <= 1'b0;
         err          <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  if (MemRead || MemWrite) begin
                     // Read+write together is a store; stores never write the register file.
                     req_wr       <= MemWrite;
                     req_addr     <= alu_result;
                     req_wdata    <= write_data;
                     req_rd       <= Rd_in;
                     req_rd_valid <= Rd_valid_in;
                     req_wreg     <= WriteReg_in & ~MemWrite;
                     state        <= REQ;
                  end else begin
                     wb_valid     <= 1'b1;
                     wb_data      <= alu_result;
                     wb_Rd        <= Rd_in;
                     wb_WriteReg  <= WriteReg_in;
                     wb_rd_valid  <= Rd_valid_in;
                  end
               end
            end
            REQ: begin
               if (!mem_stall) begin
                  cnt   <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (mem_done) begin
                  wb_valid    <= 1'b1;
                  wb_data     <= req_wr ? req_addr : mem_rdata;
                  wb_Rd       <= req_rd;
                  wb_WriteReg <= req_wreg;
                  wb_rd_valid <= req_rd_valid;
                  state       <= IDLE;
               end else if (cnt == 8'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_out = (state != IDLE);
   assign mem_en    = (state == REQ);
   assign mem_wr    = req_wr;
   assign mem_addr  = req_addr;
   assign mem_wdata = req_wdata;

   // While busy, forward from the request registers; once idle, from MEM/WB.
   assign Rd_ex_mem       = stall_out ? req_rd       : wb_Rd;
   assign Rd_valid_ex_mem = stall_out ? req_rd_valid : wb_rd_valid;
   assign WriteReg_ex_mem = stall_out ? req_wreg     : wb_WriteReg;
   assign fwd_data        = stall_out ? req_addr     : wb_data;
   assign fwd_data_ready  = !(stall_out && !req_wr);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: driver models the memory and pushes expected
// write-backs; a monitor pops and compares on every wb_valid pulse.
module tb_mem_stage_ctrl;
   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic [15:0] alu_result = '0;
   logic [15:0] write_data = '0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  Rd_in = '0;
   logic        Rd_valid_in = 1'b0;
   logic        WriteReg_in = 1'b0;
   logic        stall_out, mem_en, mem_wr;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_stall = 1'b0;
   logic        mem_done = 1'b0;
   logic [2:0]  Rd_ex_mem;
   logic        Rd_valid_ex_mem, WriteReg_ex_mem;
   logic [15:0] fwd_data;
   logic        fwd_data_ready, wb_valid;
   logic [15:0] wb_data;
   logic [2:0]  wb_Rd;
   logic        wb_WriteReg, err;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result(alu_result),
      .write_data(write_data), .MemRead(MemRead), .MemWrite(MemWrite), .Rd_in(Rd_in),
      .Rd_valid_in(Rd_valid_in), .WriteReg_in(WriteReg_in), .stall_out(stall_out),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
      .Rd_ex_mem(Rd_ex_mem), .Rd_valid_ex_mem(Rd_valid_ex_mem),
      .WriteReg_ex_mem(WriteReg_ex_mem), .fwd_data(fwd_data),
      .fwd_data_ready(fwd_data_ready), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_Rd(wb_Rd), .wb_WriteReg(wb_WriteReg), .err(err)
   );

   typedef struct {
      logic [15:0] data;
      logic [2:0]  rd;
      logic        wreg;
   } wb_t;

   wb_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write-back must match the oldest outstanding expectation.
   always @(negedge clk) begin
      wb_t e;
      if (rst_n && wb_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_wb", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wb_data", 32'(wb_data), 32'(e.data));
            check("wb_Rd", 32'(wb_Rd), 32'(e.rd));
            check("wb_WriteReg", 32'(wb_WriteReg), 32'(e.wreg));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (stall_out !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("idle_wait_expired", 32'd1, 32'd0);
   endtask

   // op: 0 non-mem, 1 load, 2 store, 3 read+write (store). ndelay >= TO means never done.
   task automatic issue(input int op, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [2:0] rd, input logic rdv, input logic wreg,
                        input int nstall, input int ndelay, input logic [15:0] rdata);
      bit is_mem = (op != 0);
      bit is_st  = (op >= 2);
      wb_t e;
      wait_idle();
      valid_in    = 1'b1;
      alu_result  = addr;
      write_data  = wd;
      MemRead     = (op == 1 || op == 3);
      MemWrite    = (op >= 2);
      Rd_in       = rd;
      Rd_valid_in = rdv;
      WriteReg_in = wreg;
      mem_done    = 1'($urandom_range(1));
      if (!is_mem) begin
         e = '{data: addr, rd: rd, wreg: wreg};
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      valid_in   = 1'($urandom_range(1));
      alu_result = 16'($urandom);
      write_data = 16'($urandom);
      Rd_in      = 3'($urandom);
      mem_done   = 1'b0;
      if (!is_mem) begin
         valid_in = 1'b0;
         check("nonmem_stall", 32'(stall_out), 32'd0);
         check("nonmem_fwd_data", 32'(fwd_data), 32'(addr));
         check("nonmem_fwd_rd", 32'(Rd_ex_mem), 32'(rd));
         check("nonmem_fwd_rdv", 32'(Rd_valid_ex_mem), 32'(rdv));
         return;
      end
      for (int i = 0; i <= nstall; i++) begin
         check("req_mem_en", 32'(mem_en), 32'd1);
         check("req_mem_addr", 32'(mem_addr), 32'(addr));
         check("req_mem_wr", 32'(mem_wr), 32'(is_st));
         check("req_mem_wdata", 32'(mem_wdata), 32'(wd));
         check("req_fwd_rd", 32'(Rd_ex_mem), 32'(rd));
         if (!is_st) begin
            check("req_fwd_ready", 32'(fwd_data_ready), 32'd0);
            check("req_fwd_wreg", 32'(WriteReg_ex_mem), 32'(wreg));
         end
         mem_stall = (i < nstall);
         mem_done  = 1'($urandom_range(1));
         @(posedge clk);
         @(negedge clk);
      end
      valid_in  = 1'b0;
      mem_stall = 1'b0;
      mem_done  = 1'b0;
      if (ndelay >= int'(TO)) begin
         for (int j = 0; j < int'(TO); j++) begin
            check("to_stall", 32'(stall_out), 32'd1);
            check("to_err_early", 32'(err), 32'd0);
            check("to_mem_en", 32'(mem_en), 32'd0);
            @(posedge clk);
            @(negedge clk);
         end
         check("to_idle", 32'(stall_out), 32'd0);
         check("to_err", 32'(err), 32'd1);
         return;
      end
      e = is_st ? '{data: addr, rd: rd, wreg: 1'b0} : '{data: rdata, rd: rd, wreg: wreg};
      exp_q.push_back(e);
      for (int j = 0; j <= ndelay; j++) begin
         check("wait_mem_en", 32'(mem_en), 32'd0);
         check("wait_stall", 32'(stall_out), 32'd1);
         if (!is_st) check("wait_fwd_ready", 32'(fwd_data_ready), 32'd0);
         mem_done  = (j == ndelay);
         mem_rdata = (j == ndelay) ? rdata : 16'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      mem_done = 1'b0;
      check("done_stall", 32'(stall_out), 32'd0);
      check("done_fwd_rd", 32'(Rd_ex_mem), 32'(rd));
      check("done_fwd_rdv", 32'(Rd_valid_ex_mem), 32'(rdv));
      check("done_fwd_ready", 32'(fwd_data_ready), 32'd1);
      check("done_fwd_data", 32'(fwd_data), 32'(is_st ? addr : rdata));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_stall", 32'(stall_out), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_data", 32'(wb_data), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd_valid", 32'(Rd_valid_ex_mem), 32'd0);
      check("rst_fwd_data", 32'(fwd_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(0, 16'h1234, 16'h0000, 3'd3, 1'b1, 1'b1, 0, 0, 16'h0000);
      issue(1, 16'h0040, 16'h0000, 3'd5, 1'b1, 1'b1, 0, 0, 16'hBEEF);
      issue(2, 16'h0010, 16'h00AA, 3'd2, 1'b1, 1'b1, 3, 1, 16'h5555);
      issue(3, 16'h0020, 16'h00BB, 3'd4, 1'b1, 1'b1, 1, 2, 16'h6666);

      for (int k = 0; k < 150; k++) begin
         issue(int'($urandom_range(3)), 16'($urandom), 16'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), int'($urandom_range(3)),
               int'($urandom_range(5)), 16'($urandom));
         if ($urandom_range(3) == 0) @(negedge clk);
      end

      issue(1, 16'h0300, 16'h0000, 3'd6, 1'b1, 1'b1, 0, 1000, 16'h0000);
      issue(0, 16'h0777, 16'h0000, 3'd1, 1'b1, 1'b1, 0, 0, 16'h0000);
      check("err_sticky", 32'(err), 32'd1);

      // Reset in the middle of a load's WAIT phase.
      wait_idle();
      valid_in = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; alu_result = 16'h0ABC;
      @(posedge clk); @(negedge clk);
      valid_in = 1'b0; mem_stall = 1'b0;
      @(posedge clk); @(negedge clk);
      check("pre_rst_wait", 32'(stall_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_mem_en", 32'(mem_en), 32'd0);
      check("midrst_stall", 32'(stall_out), 32'd0);
      check("midrst_wb_valid", 32'(wb_valid), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_done = 1'b1;
      mem_rdata = 16'hDEAD;
      @(posedge clk); @(negedge clk);
      mem_done = 1'b0;
      check("postrst_stall", 32'(stall_out), 32'd0);
      check("postrst_rd_valid", 32'(Rd_valid_ex_mem), 32'd0);
      issue(1, 16'h0042, 16'h0000, 3'd7, 1'b1, 1'b1, 0, 0, 16'hC0DE);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
